// File: rtl/fetch_unit.sv
// Instruction fetch unit: on-chip instruction memory, prefetch FIFO and valid/ready output to decode.
// Optional misaligned-redirect fault detection is enabled with `define FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_DEPTH = 256,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [XLEN-1:0]               imem_wdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                          fetch_fault,
`endif
  output logic [XLEN-1:0]               out_instr
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  logic [XLEN-1:0] mem [IMEM_DEPTH];
  logic [XLEN-1:0] rdata_reg;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] inflight_pc_reg;
  logic            inflight_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW:0]     count_reg;

  logic [XLEN-1:0] fifo_pc_reg    [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_instr_reg [FIFO_DEPTH];

  logic            fault;
  logic [XLEN-1:0] redirect_target;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW-1:0]   occupancy;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_reg <= 1'b0;
    end else if (redirect_valid) begin
      fault_reg <= |redirect_pc[1:0];
    end
  end

  assign fault           = fault_reg;
  assign fetch_fault     = fault_reg;
  assign redirect_target = redirect_pc;
`else
  assign fault           = 1'b0;
  assign redirect_target = redirect_pc & ~XLEN'(3);
`endif

  assign pop       = (count_reg != '0) & out_ready;
  // Entries already buffered or in flight, minus the one leaving this cycle.
  assign occupancy = CW'(count_reg) + CW'(inflight_reg) - CW'(pop);
  assign issue     = !redirect_valid && !fault && (occupancy < CW'(FIFO_DEPTH));
  assign push      = inflight_reg && !redirect_valid;

  // Memory has no reset; a same-edge write leaves the old word in rdata_reg.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
    if (issue) begin
      rdata_reg <= mem[fetch_pc_reg[AW+1:2]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg    <= redirect_target;
      inflight_reg    <= 1'b0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        fetch_pc_reg    <= fetch_pc_reg + XLEN'(4);
        inflight_pc_reg <= fetch_pc_reg;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Entries are reset so the presented pc/instr read zero out of reset.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          fifo_pc_reg[gi]    <= '0;
          fifo_instr_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          fifo_pc_reg[gi]    <= inflight_pc_reg;
          fifo_instr_reg[gi] <= rdata_reg;
        end
      end
    end
  endgenerate

  assign out_valid = (count_reg != '0);
  assign out_pc    = fifo_pc_reg[rd_ptr_reg];
  assign out_instr = fifo_instr_reg[rd_ptr_reg];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard testbench for fetch_unit: expected {pc, instr} queued at stimulus time, compared on each handshake.
// Define FETCH_MISALIGN_CHECK_EN for both files to exercise the fault path.
module tb_fetch_unit;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_we;
  logic [7:0]      imem_waddr;
  logic [XLEN-1:0] imem_wdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            fetch_fault;
`endif

  logic [31:0] mem_model [256];
  exp_t        sb [$];
  int          hs_cyc [$];
  int          hs_count = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          base;
  int          r_cyc;
  int          t0;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_fault    (fetch_fault),
`endif
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_model[pc[9:2]];
    sb.push_back(e);
  endtask

  // Returns at posedge+1 of the cycle after hs_count reaches target; out_ready is left unchanged.
  task automatic wait_hs_to(input int target);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (hs_count < target && n < 200);
    if (hs_count < target) check_eq("hs_timeout", 64'(hs_count), 64'(target));
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic ready);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    out_ready      = ready;
    r_cyc          = cyc;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  // Scoreboard: every handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      hs_cyc.push_back(cyc);
      hs_count++;
      $display("handshake cyc=%0d pc=0x%08h instr=0x%08h", cyc, out_pc, out_instr);
      if (sb.size() == 0) begin
        check_eq("sb_extra", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_eq("sb_pc", out_pc, e.pc);
        check_eq("sb_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, hs_count=%0d", hs_count);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 256; i++) begin
      #1;
      imem_we = 1'b1; imem_waddr = 8'(i); imem_wdata = 32'h100 + 32'(i);
      mem_model[i] = 32'h100 + 32'(i);
      @(posedge clk);
    end
    #1 imem_we = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_pc", out_pc, 64'd0);
    check_eq("rst_instr", out_instr, 64'd0);

    // Streaming from reset with out_ready high.
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1; t0 = cyc;
    for (int i = 0; i < 5; i++) push_exp(32'(4 * i));
    @(negedge clk); check_eq("first_c0_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check_eq("first_c1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check_eq("first_c2_valid", 64'(out_valid), 64'd1);
    wait_hs_to(5);
    out_ready = 1'b0;
    check_eq("first_hs_cycle", 64'(hs_cyc[0] - t0), 64'd2);
    check_eq("stream_no_gap", 64'(hs_cyc[4] - hs_cyc[0]), 64'd4);

    // Back-pressure stall, then release.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_pc", out_pc, 64'h14);
    end
    for (int i = 0; i < 4; i++) push_exp(32'h14 + 32'(4 * i));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_hs_to(9);
    out_ready = 1'b0;
    check_eq("release_no_gap", 64'(hs_cyc[8] - hs_cyc[5]), 64'd3);

    // Redirect to 0x10 while the head (0x24) pops in the same cycle.
    push_exp(32'h24);
    repeat (2) begin @(posedge clk); #1; end
    do_redirect(32'h10, 1'b1);
    for (int i = 0; i < 3; i++) push_exp(32'h10 + 32'(4 * i));
    @(negedge clk); check_eq("redir_r1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check_eq("redir_r2_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("redir_r3_valid", 64'(out_valid), 64'd1);
    check_eq("redir_r3_pc", out_pc, 64'h10);
    check_eq("redir_r3_instr", out_instr, 64'h104);
    wait_hs_to(13);
    out_ready = 1'b0;
    check_eq("redir_pop_same_cycle", 64'(hs_cyc[9]), 64'(r_cyc));

    // Reset mid-operation, then redirect in the cycle PC 8 pops.
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_pc", out_pc, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    base = hs_count;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_hs_to(base + 2);
    do_redirect(32'h20, 1'b1);
    push_exp(32'h20); push_exp(32'h24);
    wait_hs_to(base + 5);
    out_ready = 1'b0;
    check_eq("redir_pc8_same_cycle", 64'(hs_cyc[base + 2]), 64'(r_cyc));
    check_eq("redir_target_latency", 64'(hs_cyc[base + 3] - r_cyc), 64'd3);

    // Word index wrap and PC wrap.
    base = hs_count;
    do_redirect(32'h3FC, 1'b0);
    out_ready = 1'b1;
    push_exp(32'h3FC); push_exp(32'h400); push_exp(32'h404);
    wait_hs_to(base + 3);
    out_ready = 1'b0;
    do_redirect(32'hFFFF_FFFC, 1'b0);
    out_ready = 1'b1;
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    wait_hs_to(base + 5);
    out_ready = 1'b0;

    // Back-to-back redirects: the last one wins.
    do_redirect(32'h40, 1'b0);
    do_redirect(32'h50, 1'b0);
    out_ready = 1'b1;
    push_exp(32'h50); push_exp(32'h54);
    wait_hs_to(base + 7);
    out_ready = 1'b0;

`ifdef FETCH_MISALIGN_CHECK_EN
    do_redirect(32'h6, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("fault_set", 64'(fetch_fault), 64'd1);
      check_eq("fault_no_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    do_redirect(32'h8, 1'b1);
    push_exp(32'h8);
    @(negedge clk); check_eq("fault_clear", 64'(fetch_fault), 64'd0);
    @(negedge clk); check_eq("fault_r2_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("fault_r3_valid", 64'(out_valid), 64'd1);
    check_eq("fault_r3_pc", out_pc, 64'h8);
    wait_hs_to(base + 8);
    out_ready = 1'b0;
`else
    // Misaligned target has its low bits dropped.
    do_redirect(32'h16, 1'b0);
    out_ready = 1'b1;
    push_exp(32'h14);
    wait_hs_to(base + 8);
    out_ready = 1'b0;
`endif

    repeat (3) @(posedge clk);
    check_eq("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
